// File: rtl/t07_fpu_mdu_if.sv
// Request/response bundle between the FPU core and the Q16.16 multiply/divide unit.
interface t07_fpu_mdu_if;
  logic        start;
  logic        op;
  logic [31:0] inA;
  logic [31:0] inB;
  logic [31:0] result;
  logic        valid;
  logic        busy;
  logic        overflow;
  logic        divzero;

  modport master (
    output start, op, inA, inB,
    input  result, valid, busy, overflow, divzero
  );

  modport slave (
    input  start, op, inA, inB,
    output result, valid, busy, overflow, divzero
  );
endinterface

// File: rtl/t07_fpu_mdu.sv
// Sequential signed Q16.16 multiply / restoring divide with saturation.
// Magnitudes are processed unsigned; the sign is reapplied when the result is
// written, which happens on the same edge that moves the FSM into DONE.
module t07_fpu_mdu #(
  parameter int FRAC = 16
) (
  input  logic           clk,
  input  logic           nrst,
  t07_fpu_mdu_if.slave   bus
);
  localparam int DW     = 32 + FRAC;           // dividend / quotient width
  localparam int MUL_IT = 32;
  localparam int DIV_IT = DW;
  localparam int CW     = $clog2(DIV_IT + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            op_q, sign_q;
  logic [31:0]     magb_q;
  logic [63:0]     acc_q, mc_q;
  logic [31:0]     mp_q;
  logic [DW-1:0]   dq_q;                        // dividend shifts out, quotient shifts in
  logic [31:0]     rem_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     result_q;
  logic            valid_q, busy_q, ovf_q, dz_q;

  logic [31:0]     mag_a, mag_b;
  logic            accept, div_zero;
  logic [63:0]     acc_nx;
  logic [32:0]     rem_sh;
  logic            qbit;
  logic [31:0]     rem_nx;
  logic [DW-1:0]   dq_nx;
  logic            last;
  logic            ovf_fin;
  logic [31:0]     mag_fin, res_fin;

  // Operand magnitudes at accept; 0x80000000 maps to 2^31 unchanged.
  always_comb begin
    mag_a    = bus.inA[31] ? (~bus.inA + 32'd1) : bus.inA;
    mag_b    = bus.inB[31] ? (~bus.inB + 32'd1) : bus.inB;
    accept   = (state_q == S_IDLE) && bus.start;
    div_zero = bus.op && (bus.inB == 32'd0);
  end

  // One iteration of each datapath plus the saturated/signed final value.
  always_comb begin
    acc_nx  = acc_q + (mp_q[0] ? mc_q : 64'd0);
    rem_sh  = {rem_q, dq_q[DW-1]};
    qbit    = (rem_sh >= {1'b0, magb_q});
    rem_nx  = qbit ? 32'(rem_sh - {1'b0, magb_q}) : rem_sh[31:0];
    dq_nx   = {dq_q[DW-2:0], qbit};
    last    = op_q ? (cnt_q == CW'(DIV_IT - 1)) : (cnt_q == CW'(MUL_IT - 1));
    if (op_q) begin
      ovf_fin = |dq_nx[DW-1:31];
      mag_fin = dq_nx[31:0];
    end else begin
      ovf_fin = |acc_nx[63:31+FRAC];
      mag_fin = acc_nx[31+FRAC:FRAC];
    end
    if (ovf_fin) res_fin = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else         res_fin = sign_q ? (~mag_fin + 32'd1) : mag_fin;
  end

  // Next-state: divide by zero bypasses CALC entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = div_zero ? S_DONE : S_CALC;
      S_CALC: if (last)      state_d = S_DONE;
      S_DONE:                state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath, counter, result and flags.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      op_q     <= 1'b0;
      sign_q   <= 1'b0;
      magb_q   <= '0;
      acc_q    <= '0;
      mc_q     <= '0;
      mp_q     <= '0;
      dq_q     <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else if (accept) begin
      op_q   <= bus.op;
      sign_q <= bus.inA[31] ^ bus.inB[31];
      magb_q <= mag_b;
      acc_q  <= '0;
      mc_q   <= {32'd0, mag_a};
      mp_q   <= mag_b;
      dq_q   <= {mag_a, {FRAC{1'b0}}};
      rem_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      dz_q   <= div_zero;
      if (div_zero) result_q <= bus.inA[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (state_q == S_CALC) begin
      cnt_q <= cnt_q + CW'(1);
      if (op_q) begin
        rem_q <= rem_nx;
        dq_q  <= dq_nx;
      end else begin
        acc_q <= acc_nx;
        mc_q  <= {mc_q[62:0], 1'b0};
        mp_q  <= {1'b0, mp_q[31:1]};
      end
      if (last) begin
        result_q <= res_fin;
        ovf_q    <= ovf_fin;
      end
    end
  end

  // Registered handshake outputs, decoded from the upcoming state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= (state_d == S_DONE);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign bus.result   = result_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = ovf_q;
  assign bus.divzero  = dz_q;
endmodule
